// File: rtl/lr35902_oam_dma.sv
// ---------------------------------------------------------------------------
// lr35902_oam_dma
//
// Sprite attribute (OAM) DMA engine for an LR35902-style system. A CPU write
// to the source register (REG_ADR, normally FF46) latches the source page and
// starts a 160-byte copy from {page,00..9F} into OAM indices 00..9F. Each byte
// takes one read cycle (RD) followed by one write cycle (WR), preceded by a
// single START cycle, so a full transfer keeps 'active' high for 321 cycles.
//
// Ports
//   clk        in   1  system clock, all state changes on the rising edge
//   n_reset    in   1  synchronous active-low reset
//   adr        in  16  CPU address bus
//   din        in   8  CPU write data
//   write      in   1  CPU write strobe
//   read       in   1  CPU read strobe
//   dout       out  8  source register read data (last written value)
//   drv        out  1  dout is valid for the CPU data-bus merge
//   dma_adr    out 16  source address toward the memory map
//   dma_read   out  1  source read strobe (RD cycles only)
//   dma_din    in   8  source read data, valid in the same cycle as dma_read
//   oam_adr    out  8  OAM destination index
//   oam_dout   out  8  OAM write data
//   oam_write  out  1  OAM write strobe (WR cycles only)
//   active     out  1  transfer in progress (START, RD or WR)
// ---------------------------------------------------------------------------
module lr35902_oam_dma #(
  parameter logic [15:0] REG_ADR = 16'hFF46
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] adr,
  input  logic [7:0]  din,
  input  logic        write,
  input  logic        read,
  output logic [7:0]  dout,
  output logic        drv,
  output logic [15:0] dma_adr,
  output logic        dma_read,
  input  logic [7:0]  dma_din,
  output logic [7:0]  oam_adr,
  output logic [7:0]  oam_dout,
  output logic        oam_write,
  output logic        active
);

  localparam logic [7:0] LAST_IDX = 8'd159;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RD    = 2'd2,
    ST_WR    = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  idx_reg, idx_next;
  logic [7:0]  src_reg, src_next;
  logic [7:0]  latch_reg, latch_next;
  logic [15:0] dma_adr_reg, dma_adr_next;
  logic        dma_read_reg, dma_read_next;
  logic [7:0]  oam_adr_reg, oam_adr_next;
  logic [7:0]  oam_dout_reg, oam_dout_next;
  logic        oam_write_reg, oam_write_next;
  logic        active_reg, active_next;
  logic [7:0]  srcmap_next;
  logic        trigger;

  // A write to the source register is the only command; reads and writes to
  // any other address never touch the state machine.
  assign trigger = write && (adr == REG_ADR);

  // Register read path depends on inputs only, so it keeps working in reset.
  assign drv  = read && (adr == REG_ADR);
  assign dout = src_reg;

  assign dma_adr   = dma_adr_reg;
  assign dma_read  = dma_read_reg;
  assign oam_adr   = oam_adr_reg;
  assign oam_dout  = oam_dout_reg;
  assign oam_write = oam_write_reg;
  assign active    = active_reg;

  // -------------------------------------------------------------------------
  // State register. All outputs are registered from the next-state values so
  // each strobe lines up exactly with the state it belongs to.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= 8'h00;
      src_reg       <= 8'h00;
      latch_reg     <= 8'h00;
      dma_adr_reg   <= 16'h0000;
      dma_read_reg  <= 1'b0;
      oam_adr_reg   <= 8'h00;
      oam_dout_reg  <= 8'h00;
      oam_write_reg <= 1'b0;
      active_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      src_reg       <= src_next;
      latch_reg     <= latch_next;
      dma_adr_reg   <= dma_adr_next;
      dma_read_reg  <= dma_read_next;
      oam_adr_reg   <= oam_adr_next;
      oam_dout_reg  <= oam_dout_next;
      oam_write_reg <= oam_write_next;
      active_reg    <= active_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and next-output logic.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    src_next       = src_reg;
    latch_next     = latch_reg;
    dma_adr_next   = dma_adr_reg;
    dma_read_next  = 1'b0;
    oam_adr_next   = oam_adr_reg;
    oam_dout_next  = oam_dout_reg;
    oam_write_next = 1'b0;
    active_next    = 1'b0;
    srcmap_next    = 8'h00;

    case (state_reg)
      ST_IDLE: begin
        state_next = ST_IDLE;
      end
      ST_START: begin
        state_next = ST_RD;
        idx_next   = 8'h00;
      end
      ST_RD: begin
        state_next = ST_WR;
        latch_next = dma_din;
      end
      ST_WR: begin
        // idx stops at 159; it is never incremented past the last index.
        if (idx_reg == LAST_IDX) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_RD;
          idx_next   = idx_reg + 8'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // A trigger overrides the normal sequence from any state, including a
    // restart mid-transfer. The WR strobe of the current cycle is already on
    // the outputs, so a trigger in the last WR cycle still completes index 159.
    // Whatever RD just fetched is dropped.
    if (trigger) begin
      src_next   = din;
      state_next = ST_START;
      latch_next = latch_reg;
    end

    // Echo RAM pages E0..FF alias the work RAM at C0..DF.
    if (src_next > 8'hDF) begin
      srcmap_next = src_next - 8'h20;
    end else begin
      srcmap_next = src_next;
    end

    active_next = (state_next != ST_IDLE);

    if (state_next == ST_RD) begin
      dma_read_next = 1'b1;
      dma_adr_next  = {srcmap_next, idx_next};
    end

    if (state_next == ST_WR) begin
      oam_write_next = 1'b1;
      oam_adr_next   = idx_next;
      oam_dout_next  = latch_next;
    end
  end

endmodule

// File: tb/tb_lr35902_oam_dma.sv
module tb_lr35902_oam_dma;

  logic        clk;
  logic        n_reset;
  logic [15:0] adr;
  logic [7:0]  din;
  logic        write;
  logic        read;
  logic [7:0]  dout;
  logic        drv;
  logic [15:0] dma_adr;
  logic        dma_read;
  logic [7:0]  dma_din;
  logic [7:0]  oam_adr;
  logic [7:0]  oam_dout;
  logic        oam_write;
  logic        active;

  int n_vec = 0;
  int n_bad = 0;

  lr35902_oam_dma #(.REG_ADR(16'hFF46)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .adr       (adr),
    .din       (din),
    .write     (write),
    .read      (read),
    .dout      (dout),
    .drv       (drv),
    .dma_adr   (dma_adr),
    .dma_read  (dma_read),
    .dma_din   (dma_din),
    .oam_adr   (oam_adr),
    .oam_dout  (oam_dout),
    .oam_write (oam_write),
    .active    (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source memory contents: page C1 holds i^5A, other pages are offset so
  // every page used below has a distinct image.
  function automatic logic [7:0] pat(input logic [7:0] hi, input logic [7:0] lo);
    return lo ^ 8'h5A ^ (hi + 8'h3F);
  endfunction

  assign dma_din = pat(dma_adr[15:8], dma_adr[7:0]);

  // Recorder of DUT activity: OAM image, strobe counts, read address log.
  logic [7:0]  oam_mem [160];
  logic [15:0] rd_log  [4096];
  int act_cnt = 0;
  int wr_cnt  = 0;
  int rd_cnt  = 0;

  always @(posedge clk) begin
    if (active) act_cnt <= act_cnt + 1;
    if (oam_write) begin
      wr_cnt <= wr_cnt + 1;
      if (oam_adr < 8'd160) oam_mem[oam_adr] <= oam_dout;
    end
    if (dma_read) begin
      rd_log[rd_cnt[11:0]] <= dma_adr;
      rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic trig(input logic [7:0] v);
    adr   = 16'hFF46;
    din   = v;
    write = 1'b1;
    tick();
    write = 1'b0;
    adr   = 16'h0000;
    din   = 8'h00;
  endtask

  // Returns when active drops; an expired budget counts as a miscompare.
  task automatic wait_idle(input string name, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (!active) break;
      tick();
    end
    chk({name, "_idle_timeout"}, {31'd0, active}, 32'd0);
  endtask

  // Waits for an RD cycle at the given index.
  task automatic wait_rd(input string name, input logic [7:0] idx);
    int k;
    logic found;
    found = 1'b0;
    for (k = 0; k < 400; k++) begin
      if (dma_read && dma_adr[7:0] == idx) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk({name, "_rd_found"}, {31'd0, found}, 32'd1);
  endtask

  typedef struct packed {
    logic        n_reset;
    logic [15:0] adr;
    logic [7:0]  din;
    logic        write;
    logic        read;
    logic        exp_drv;
    logic [7:0]  exp_dout;
    logic        exp_active;
  } vec_t;

  vec_t vecs [8];

  int act_base, wr_base, rd_base;

  initial begin
    // n_reset adr din write read | drv(pre-edge) dout(post) active(post)
    vecs[0] = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 16'hFF46, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 16'hFF45, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{1'b1, 16'hFF45, 8'h77, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{1'b1, 16'hFF46, 8'h12, 1'b1, 1'b0, 1'b0, 8'h12, 1'b1};
    vecs[5] = '{1'b0, 16'hFF46, 8'h34, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[6] = '{1'b1, 16'hFF46, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[7] = '{1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};

    n_reset = 1'b0;
    adr     = 16'h0000;
    din     = 8'h00;
    write   = 1'b0;
    read    = 1'b0;
    tick();
    tick();

    // ---------------- table-driven register / reset vectors ----------------
    for (int i = 0; i < 8; i++) begin
      n_reset = vecs[i].n_reset;
      adr     = vecs[i].adr;
      din     = vecs[i].din;
      write   = vecs[i].write;
      read    = vecs[i].read;
      #1;
      chk($sformatf("vec%0d_drv", i), {31'd0, drv}, {31'd0, vecs[i].exp_drv});
      tick();
      chk($sformatf("vec%0d_dout", i), {24'd0, dout}, {24'd0, vecs[i].exp_dout});
      chk($sformatf("vec%0d_active", i), {31'd0, active}, {31'd0, vecs[i].exp_active});
      chk($sformatf("vec%0d_strobes", i), {30'd0, dma_read, oam_write}, 32'd0);
    end
    n_reset = 1'b1;
    adr = 16'h0000; din = 8'h00; write = 1'b0; read = 1'b0;
    tick();

    // ---------------- full transfer from C1 ----------------
    act_base = act_cnt; wr_base = wr_cnt; rd_base = rd_cnt;
    trig(8'hC1);
    wait_idle("c1", 400);
    chk("c1_active_cycles", act_cnt - act_base, 32'd321);
    chk("c1_oam_writes", wr_cnt - wr_base, 32'd160);
    chk("c1_dma_reads", rd_cnt - rd_base, 32'd160);
    for (int i = 0; i < 160; i++)
      chk($sformatf("c1_oam%0d", i), {24'd0, oam_mem[i]}, {24'd0, 8'(i) ^ 8'h5A});
    $display("transfer C1: %0d active cycles, %0d OAM writes", act_cnt - act_base, wr_cnt - wr_base);

    // ---------------- echo page E3 maps to C3 ----------------
    rd_base = rd_cnt;
    trig(8'hE3);
    wait_idle("e3", 400);
    chk("e3_dma_reads", rd_cnt - rd_base, 32'd160);
    for (int i = 0; i < 160; i++)
      chk($sformatf("e3_adr%0d", i), {16'd0, rd_log[(rd_base + i) % 4096]}, {16'd0, 16'hC300 + 16'(i)});
    chk("e3_oam10", {24'd0, oam_mem[10]}, {24'd0, pat(8'hC3, 8'd10)});
    $display("transfer E3: first source %h, last source %h", rd_log[rd_base % 4096], rd_log[(rd_base + 159) % 4096]);

    // ---------------- restart at idx 50, plus register reads mid-transfer ----
    act_base = act_cnt; wr_base = wr_cnt;
    trig(8'hC0);
    for (int k = 0; k < 10; k++) tick();
    read = 1'b1; adr = 16'hFF46;
    #1;
    chk("mid_rd_drv", {31'd0, drv}, 32'd1);
    chk("mid_rd_dout", {24'd0, dout}, 32'h0000_00C0);
    adr = 16'hFF45;
    #1;
    chk("mid_rd_ff45_drv", {31'd0, drv}, 32'd0);
    read = 1'b0; adr = 16'h0000;
    wait_rd("c0", 8'd50);
    chk("c0_writes_before_restart", wr_cnt - wr_base, 32'd50);
    chk("c0_oam0", {24'd0, oam_mem[0]}, {24'd0, pat(8'hC0, 8'd0)});
    chk("c0_oam49", {24'd0, oam_mem[49]}, {24'd0, pat(8'hC0, 8'd49)});
    chk("c0_oam50_untouched", {24'd0, oam_mem[50]}, {24'd0, pat(8'hC3, 8'd50)});
    trig(8'hD0);
    chk("restart_active", {31'd0, active}, 32'd1);
    chk("restart_no_wr", {31'd0, oam_write}, 32'd0);
    wait_idle("d0", 400);
    chk("restart_active_cycles", act_cnt - act_base, 32'd423);
    chk("restart_oam_writes", wr_cnt - wr_base, 32'd210);
    for (int i = 0; i < 160; i++)
      chk($sformatf("d0_oam%0d", i), {24'd0, oam_mem[i]}, {24'd0, pat(8'hD0, 8'(i))});
    $display("restart C0->D0: %0d active cycles, %0d OAM writes", act_cnt - act_base, wr_cnt - wr_base);

    // ---------------- trigger on the final WR cycle ----------------
    act_base = act_cnt; wr_base = wr_cnt;
    trig(8'hC5);
    begin
      int k;
      logic found;
      found = 1'b0;
      for (k = 0; k < 400; k++) begin
        if (oam_write && oam_adr == 8'd159) begin
          found = 1'b1;
          break;
        end
        tick();
      end
      chk("c5_last_wr_found", {31'd0, found}, 32'd1);
    end
    trig(8'hC7);
    chk("c5_oam159", {24'd0, oam_mem[159]}, {24'd0, pat(8'hC5, 8'd159)});
    chk("c5_then_start_active", {31'd0, active}, 32'd1);
    chk("c5_then_start_strobes", {30'd0, dma_read, oam_write}, 32'd0);
    wait_idle("c7", 400);
    chk("c5c7_active_cycles", act_cnt - act_base, 32'd642);
    chk("c5c7_oam_writes", wr_cnt - wr_base, 32'd320);
    for (int i = 0; i < 160; i++)
      chk($sformatf("c7_oam%0d", i), {24'd0, oam_mem[i]}, {24'd0, pat(8'hC7, 8'(i))});
    $display("back-to-back C5->C7: %0d active cycles, %0d OAM writes", act_cnt - act_base, wr_cnt - wr_base);

    // ---------------- reset at idx 80 ----------------
    wr_base = wr_cnt;
    trig(8'hD2);
    wait_rd("d2", 8'd80);
    n_reset = 1'b0;
    tick();
    n_reset = 1'b1;
    chk("rst_active", {31'd0, active}, 32'd0);
    chk("rst_oam_write", {31'd0, oam_write}, 32'd0);
    chk("rst_dma_read", {31'd0, dma_read}, 32'd0);
    chk("rst_dma_adr", {16'd0, dma_adr}, 32'd0);
    chk("rst_oam_adr_dout", {16'd0, oam_adr, oam_dout}, 32'd0);
    for (int k = 0; k < 5; k++) tick();
    chk("rst_stays_idle", {31'd0, active}, 32'd0);
    chk("rst_oam_writes", wr_cnt - wr_base, 32'd80);
    for (int i = 0; i < 80; i++)
      chk($sformatf("d2_oam%0d", i), {24'd0, oam_mem[i]}, {24'd0, pat(8'hD2, 8'(i))});
    for (int i = 80; i < 160; i++)
      chk($sformatf("rst_kept_oam%0d", i), {24'd0, oam_mem[i]}, {24'd0, pat(8'hC7, 8'(i))});
    read = 1'b1; adr = 16'hFF46;
    #1;
    chk("rst_rd_drv", {31'd0, drv}, 32'd1);
    chk("rst_rd_dout", {24'd0, dout}, 32'd0);
    read = 1'b0; adr = 16'h0000;
    $display("reset at idx 80: %0d OAM writes before abort", wr_cnt - wr_base);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
